// File: rtl/sensor_poll_ctrl.sv
// Periodic I2C sensor poller: triggers the read engine every POLL_DIV cycles and publishes samples.
// Optional 4-sample moving average when SENSOR_POLL_AVG_EN is defined.
module sensor_poll_ctrl #(
   parameter int unsigned POLL_DIV = 50000,
   parameter int unsigned TIMEOUT  = 4095
) (
   input  logic        PT_CK,
   input  logic        RESET_N,
   input  logic        ENABLE,
   output logic        I2C_GO,
   input  logic        I2C_END_OK,
   input  logic        I2C_ACK_OK,
   input  logic [15:0] I2C_DATA16,
   output logic [15:0] SAMPLE,
   output logic        SAMPLE_VALID,
   output logic        ERR_NACK,
   output logic        ERR_TIMEOUT,
   output logic [15:0] SAMPLE_CNT,
   input  logic        ERR_CLR
);

   localparam int unsigned POLL_W = 24;
   localparam int unsigned TO_W   = 16;
   localparam int unsigned DATA_W = 16;

   localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_DIV - 1);
   localparam logic [TO_W-1:0]   TO_LIMIT  = TO_W'(TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_TRIG    = 2'd1,
      ST_BUSY    = 2'd2,
      ST_CAPTURE = 2'd3
   } state_t;

   state_t              r_state;
   logic [POLL_W-1:0]   r_poll_cnt;
   logic [TO_W-1:0]     r_to_cnt;
   logic                r_ack_seen;
   logic                r_go;
   logic [DATA_W-1:0]   r_sample;
   logic                r_valid;
   logic                r_err_nack;
   logic                r_err_to;
   logic [DATA_W-1:0]   r_sample_cnt;

   logic [TO_W-1:0]     w_to_next;
   logic                w_to_fire;

   // Counter holds cycles already spent in TRIG/BUSY; fire once it would reach TIMEOUT
   assign w_to_next = r_to_cnt + TO_W'(1);
   assign w_to_fire = (w_to_next == TO_LIMIT);

`ifdef SENSOR_POLL_AVG_EN
   logic [DATA_W-1:0]   r_hist0;
   logic [DATA_W-1:0]   r_hist1;
   logic [DATA_W-1:0]   r_hist2;
   logic [2:0]          r_fill;
   logic [17:0]         w_sum;
   logic [DATA_W-1:0]   w_avg;
   logic                w_avg_ready;

   assign w_sum       = 18'(I2C_DATA16) + 18'(r_hist0) + 18'(r_hist1) + 18'(r_hist2);
   assign w_avg       = DATA_W'(w_sum >> 2);
   assign w_avg_ready = (r_fill >= 3'd3);
`endif

   // Poll/transaction sequencer with registered engine trigger and status outputs
   always_ff @(posedge PT_CK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state      <= ST_IDLE;
         r_poll_cnt   <= '0;
         r_to_cnt     <= '0;
         r_ack_seen   <= 1'b0;
         r_go         <= 1'b1;
         r_sample     <= '0;
         r_valid      <= 1'b0;
         r_err_nack   <= 1'b0;
         r_err_to     <= 1'b0;
         r_sample_cnt <= '0;
`ifdef SENSOR_POLL_AVG_EN
         r_hist0      <= '0;
         r_hist1      <= '0;
         r_hist2      <= '0;
         r_fill       <= '0;
`endif
      end else begin
         r_valid <= 1'b0;

         // Clear first so a same-cycle error event below takes precedence
         if (ERR_CLR) begin
            r_err_nack <= 1'b0;
            r_err_to   <= 1'b0;
         end

         case (r_state)
            ST_IDLE: begin
               r_go <= 1'b1;
               if (!ENABLE) begin
                  r_poll_cnt <= '0;
               end else if (r_poll_cnt == POLL_LAST) begin
                  r_poll_cnt <= '0;
                  r_to_cnt   <= '0;
                  r_go       <= 1'b0;
                  r_state    <= ST_TRIG;
               end else begin
                  r_poll_cnt <= r_poll_cnt + POLL_W'(1);
               end
            end

            ST_TRIG: begin
               if (!I2C_END_OK) begin
                  r_to_cnt <= '0;
                  r_go     <= 1'b1;
                  r_state  <= ST_BUSY;
               end else if (w_to_fire) begin
                  r_to_cnt <= '0;
                  r_go     <= 1'b1;
                  r_err_to <= 1'b1;
                  r_state  <= ST_IDLE;
               end else begin
                  r_to_cnt <= w_to_next;
               end
            end

            ST_BUSY: begin
               r_go <= 1'b1;
               if (I2C_ACK_OK) begin
                  r_ack_seen <= 1'b1;
               end
               if (I2C_END_OK) begin
                  r_to_cnt <= '0;
                  r_state  <= ST_CAPTURE;
               end else if (w_to_fire) begin
                  r_to_cnt   <= '0;
                  r_ack_seen <= 1'b0;
                  r_err_to   <= 1'b1;
                  r_state    <= ST_IDLE;
               end else begin
                  r_to_cnt <= w_to_next;
               end
            end

            ST_CAPTURE: begin
               r_go <= 1'b1;
               if (r_ack_seen) begin
                  r_sample_cnt <= r_sample_cnt + DATA_W'(1);
`ifdef SENSOR_POLL_AVG_EN
                  r_hist0 <= I2C_DATA16;
                  r_hist1 <= r_hist0;
                  r_hist2 <= r_hist1;
                  if (w_avg_ready) begin
                     r_sample <= w_avg;
                     r_valid  <= 1'b1;
                  end else begin
                     r_fill <= r_fill + 3'd1;
                  end
`else
                  r_sample <= I2C_DATA16;
                  r_valid  <= 1'b1;
`endif
               end else begin
                  r_err_nack <= 1'b1;
               end
               r_ack_seen <= 1'b0;
               r_poll_cnt <= '0;
               r_state    <= ST_IDLE;
            end

            default: begin
               r_go    <= 1'b1;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign I2C_GO       = r_go;
   assign SAMPLE       = r_sample;
   assign SAMPLE_VALID = r_valid;
   assign ERR_NACK     = r_err_nack;
   assign ERR_TIMEOUT  = r_err_to;
   assign SAMPLE_CNT   = r_sample_cnt;

endmodule

// File: tb/tb_sensor_poll_ctrl.sv
// Directed self-checking bench for sensor_poll_ctrl with a task-driven I2C engine model.
module tb_sensor_poll_ctrl;

   localparam int unsigned POLL_DIV = 8;
   localparam int unsigned TIMEOUT  = 16;

   logic        PT_CK = 1'b0;
   logic        RESET_N = 1'b0;
   logic        ENABLE = 1'b0;
   logic        I2C_GO;
   logic        I2C_END_OK = 1'b1;
   logic        I2C_ACK_OK = 1'b0;
   logic [15:0] I2C_DATA16 = 16'h0000;
   logic [15:0] SAMPLE;
   logic        SAMPLE_VALID;
   logic        ERR_NACK;
   logic        ERR_TIMEOUT;
   logic [15:0] SAMPLE_CNT;
   logic        ERR_CLR = 1'b0;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_sample = 16'h0000;
   logic [15:0] exp_cnt = 16'h0000;

   sensor_poll_ctrl #(
      .POLL_DIV (POLL_DIV),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .PT_CK        (PT_CK),
      .RESET_N      (RESET_N),
      .ENABLE       (ENABLE),
      .I2C_GO       (I2C_GO),
      .I2C_END_OK   (I2C_END_OK),
      .I2C_ACK_OK   (I2C_ACK_OK),
      .I2C_DATA16   (I2C_DATA16),
      .SAMPLE       (SAMPLE),
      .SAMPLE_VALID (SAMPLE_VALID),
      .ERR_NACK     (ERR_NACK),
      .ERR_TIMEOUT  (ERR_TIMEOUT),
      .SAMPLE_CNT   (SAMPLE_CNT),
      .ERR_CLR      (ERR_CLR)
   );

   always #5 PT_CK = ~PT_CK;

   task automatic apply_reset();
      RESET_N    = 1'b0;
      ENABLE     = 1'b0;
      I2C_END_OK = 1'b1;
      I2C_ACK_OK = 1'b0;
      I2C_DATA16 = 16'h0000;
      ERR_CLR    = 1'b0;
      repeat (2) @(negedge PT_CK);
      RESET_N    = 1'b1;
      exp_sample = 16'h0000;
      exp_cnt    = 16'h0000;
   endtask

   // Returns number of clock edges until I2C_GO is seen low (bounded)
   task automatic wait_go_low(input int limit, output int n);
      n = 0;
      while (I2C_GO !== 1'b0 && n < limit) begin
         @(negedge PT_CK);
         n++;
      end
   endtask

   // Engine model: called while in TRIG; returns on the cycle after CAPTURE
   task automatic run_txn(input logic ack, input logic [15:0] data, input logic clr);
      I2C_END_OK = 1'b0;
      @(negedge PT_CK);
      I2C_ACK_OK = ack;
      @(negedge PT_CK);
      I2C_ACK_OK = 1'b0;
      I2C_END_OK = 1'b1;
      I2C_DATA16 = data;
      @(negedge PT_CK);
      ERR_CLR = clr;
      @(negedge PT_CK);
      ERR_CLR = 1'b0;
   endtask

   task automatic test_reset();
      RESET_N = 1'b0;
      @(negedge PT_CK);
      checks++; if (I2C_GO !== 1'b1) begin errors++; $display("FAIL reset_go: got %b exp 1", I2C_GO); end
      checks++; if (SAMPLE !== 16'h0000) begin errors++; $display("FAIL reset_sample: got %h exp 0000", SAMPLE); end
      checks++; if (SAMPLE_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", SAMPLE_VALID); end
      checks++; if (ERR_NACK !== 1'b0 || ERR_TIMEOUT !== 1'b0) begin errors++; $display("FAIL reset_err: got nack=%b to=%b exp 0/0", ERR_NACK, ERR_TIMEOUT); end
      checks++; if (SAMPLE_CNT !== 16'h0000) begin errors++; $display("FAIL reset_cnt: got %h exp 0000", SAMPLE_CNT); end
   endtask

   task automatic test_basic();
      int n;
      logic        exp_v;
      apply_reset();
      ENABLE = 1'b1;
      wait_go_low(50, n);
      checks++; if (n != 8 || I2C_GO !== 1'b0) begin errors++; $display("FAIL basic_go_latency: got %0d go=%b exp 8 go=0", n, I2C_GO); end
      run_txn(1'b1, 16'h1234, 1'b0);
      exp_cnt = 16'h0001;
`ifdef SENSOR_POLL_AVG_EN
      exp_v = 1'b0;
`else
      exp_v = 1'b1;
      exp_sample = 16'h1234;
`endif
      checks++; if (SAMPLE_VALID !== exp_v) begin errors++; $display("FAIL basic_valid: got %b exp %b", SAMPLE_VALID, exp_v); end
      checks++; if (SAMPLE !== exp_sample) begin errors++; $display("FAIL basic_sample: got %h exp %h", SAMPLE, exp_sample); end
      checks++; if (SAMPLE_CNT !== exp_cnt) begin errors++; $display("FAIL basic_cnt: got %h exp %h", SAMPLE_CNT, exp_cnt); end
      checks++; if (ERR_NACK !== 1'b0) begin errors++; $display("FAIL basic_nack: got %b exp 0", ERR_NACK); end
      @(negedge PT_CK);
      checks++; if (SAMPLE_VALID !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse: got %b exp 0", SAMPLE_VALID); end
   endtask

   task automatic test_nack();
      int n;
      wait_go_low(50, n);
      run_txn(1'b0, 16'hBEEF, 1'b0);
      checks++; if (SAMPLE_VALID !== 1'b0) begin errors++; $display("FAIL nack_valid: got %b exp 0", SAMPLE_VALID); end
      checks++; if (ERR_NACK !== 1'b1) begin errors++; $display("FAIL nack_flag: got %b exp 1", ERR_NACK); end
      checks++; if (SAMPLE !== exp_sample) begin errors++; $display("FAIL nack_sample: got %h exp %h", SAMPLE, exp_sample); end
      checks++; if (SAMPLE_CNT !== exp_cnt) begin errors++; $display("FAIL nack_cnt: got %h exp %h", SAMPLE_CNT, exp_cnt); end
   endtask

   task automatic test_set_wins();
      int n;
      ERR_CLR = 1'b1;
      @(negedge PT_CK);
      ERR_CLR = 1'b0;
      checks++; if (ERR_NACK !== 1'b0) begin errors++; $display("FAIL clr_nack: got %b exp 0", ERR_NACK); end
      wait_go_low(50, n);
      run_txn(1'b0, 16'h5555, 1'b1);
      checks++; if (ERR_NACK !== 1'b1) begin errors++; $display("FAIL set_wins_nack: got %b exp 1", ERR_NACK); end
   endtask

   task automatic test_timeout();
      int n;
      int n_low;
      checks++; if (ERR_TIMEOUT !== 1'b0) begin errors++; $display("FAIL timeout_pre: got %b exp 0", ERR_TIMEOUT); end
      wait_go_low(50, n);
      n_low = 0;
      while (I2C_GO === 1'b0 && n_low < 100) begin
         @(negedge PT_CK);
         n_low++;
      end
      ENABLE = 1'b0;
      checks++; if (n_low != 16) begin errors++; $display("FAIL timeout_trig_cycles: got %0d exp 16", n_low); end
      checks++; if (ERR_TIMEOUT !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b exp 1", ERR_TIMEOUT); end
      checks++; if (SAMPLE_CNT !== exp_cnt) begin errors++; $display("FAIL timeout_cnt: got %h exp %h", SAMPLE_CNT, exp_cnt); end
      ERR_CLR = 1'b1;
      @(negedge PT_CK);
      ERR_CLR = 1'b0;
      checks++; if (ERR_TIMEOUT !== 1'b0 || ERR_NACK !== 1'b0) begin errors++; $display("FAIL timeout_clr: got to=%b nack=%b exp 0/0", ERR_TIMEOUT, ERR_NACK); end
   endtask

   task automatic test_samples();
      int n;
      logic [15:0] data;
      logic [15:0] s_exp [5];
      logic        v_exp [5];
`ifdef SENSOR_POLL_AVG_EN
      s_exp = '{16'h0000, 16'h0000, 16'h0000, 16'h000A, 16'h000E};
      v_exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`else
      s_exp = '{16'h0004, 16'h0008, 16'h000C, 16'h0010, 16'h0014};
      v_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
      apply_reset();
      ENABLE = 1'b1;
      for (int i = 0; i < 5; i++) begin
         data = 16'(4 * (i + 1));
         wait_go_low(50, n);
         checks++; if (n != 8) begin errors++; $display("FAIL samples_interval[%0d]: got %0d exp 8", i, n); end
         run_txn(1'b1, data, 1'b0);
         checks++; if (SAMPLE_VALID !== v_exp[i]) begin errors++; $display("FAIL samples_valid[%0d]: got %b exp %b", i, SAMPLE_VALID, v_exp[i]); end
         checks++; if (SAMPLE !== s_exp[i]) begin errors++; $display("FAIL samples_value[%0d]: got %h exp %h", i, SAMPLE, s_exp[i]); end
         checks++; if (SAMPLE_CNT !== 16'(i + 1)) begin errors++; $display("FAIL samples_cnt[%0d]: got %h exp %h", i, SAMPLE_CNT, 16'(i + 1)); end
      end
   endtask

   task automatic test_enable_drop();
      int n;
      int n_low;
      logic [15:0] s_exp;
`ifdef SENSOR_POLL_AVG_EN
      s_exp = 16'h02BB;
`else
      s_exp = 16'h0ABC;
`endif
      wait_go_low(50, n);
      I2C_END_OK = 1'b0;
      @(negedge PT_CK);
      ENABLE     = 1'b0;
      I2C_ACK_OK = 1'b1;
      @(negedge PT_CK);
      I2C_ACK_OK = 1'b0;
      I2C_END_OK = 1'b1;
      I2C_DATA16 = 16'h0ABC;
      @(negedge PT_CK);
      @(negedge PT_CK);
      checks++; if (SAMPLE_VALID !== 1'b1) begin errors++; $display("FAIL endrop_valid: got %b exp 1", SAMPLE_VALID); end
      checks++; if (SAMPLE !== s_exp) begin errors++; $display("FAIL endrop_sample: got %h exp %h", SAMPLE, s_exp); end
      checks++; if (SAMPLE_CNT !== 16'h0006) begin errors++; $display("FAIL endrop_cnt: got %h exp 0006", SAMPLE_CNT); end
      n_low = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge PT_CK);
         if (I2C_GO !== 1'b1) n_low++;
      end
      checks++; if (n_low != 0) begin errors++; $display("FAIL endrop_no_trigger: got %0d low cycles exp 0", n_low); end
   endtask

   task automatic test_reset_mid_txn();
      int n;
      ENABLE = 1'b1;
      wait_go_low(50, n);
      RESET_N = 1'b0;
      #1;
      checks++; if (I2C_GO !== 1'b1) begin errors++; $display("FAIL rst_trig_go: got %b exp 1", I2C_GO); end
      @(negedge PT_CK);
      RESET_N = 1'b1;
      wait_go_low(50, n);
      checks++; if (n != 8) begin errors++; $display("FAIL rst_trig_interval: got %0d exp 8", n); end
      I2C_END_OK = 1'b0;
      @(negedge PT_CK);
      I2C_ACK_OK = 1'b1;
      @(negedge PT_CK);
      RESET_N = 1'b0;
      #1;
      checks++; if (I2C_GO !== 1'b1 || SAMPLE_VALID !== 1'b0) begin errors++; $display("FAIL rst_busy_go_valid: got go=%b valid=%b exp 1/0", I2C_GO, SAMPLE_VALID); end
      checks++; if (SAMPLE !== 16'h0000 || SAMPLE_CNT !== 16'h0000) begin errors++; $display("FAIL rst_busy_data: got sample=%h cnt=%h exp 0000/0000", SAMPLE, SAMPLE_CNT); end
      checks++; if (ERR_NACK !== 1'b0 || ERR_TIMEOUT !== 1'b0) begin errors++; $display("FAIL rst_busy_err: got nack=%b to=%b exp 0/0", ERR_NACK, ERR_TIMEOUT); end
      @(negedge PT_CK);
      I2C_ACK_OK = 1'b0;
      I2C_END_OK = 1'b1;
      RESET_N    = 1'b1;
      wait_go_low(50, n);
      checks++; if (n != 8) begin errors++; $display("FAIL rst_busy_interval: got %0d exp 8", n); end
      run_txn(1'b0, 16'h7777, 1'b0);
      checks++; if (ERR_NACK !== 1'b1 || SAMPLE_CNT !== 16'h0000) begin errors++; $display("FAIL rst_ack_cleared: got nack=%b cnt=%h exp 1/0000", ERR_NACK, SAMPLE_CNT); end
      ENABLE = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_nack();
      test_set_wins();
      test_timeout();
      test_samples();
      test_enable_drop();
      test_reset_mid_txn();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
